// File: rtl/sel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sel_scan_ctrl
//
// Drives the select code of a downstream 4-to-1 selector through the enabled
// channels in ascending order. Each enabled channel is held for D cycles,
// where D = max(DWELL, 1). On the last cycle of that dwell the selector's
// returned data bit is captured into SAMPLE for that channel. Disabled channels
// are skipped and keep their previous SAMPLE bit. A one-cycle DONE pulse marks
// the end of the scan. All outputs come straight from flops.
//
// Ports
//   CLK       in   1        clock, rising edge
//   RST       in   1        asynchronous, active-high reset
//   START     in   1        scan request; only accepted in IDLE
//   MASK      in   4        channel enables, latched at START
//   DWELL     in   DWELL_W  cycles per channel, latched at START (0 acts as 1)
//   SEL_DATA  in   1        data bit returned by the downstream selector
//   SEL_OUT   out  2        select code to the downstream selector
//   SAMPLE    out  4        captured bit per channel
//   BUSY      out  1        high while scanning
//   DONE      out  1        one-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module sel_scan_ctrl #(
   parameter int DWELL_W = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [3:0]         MASK,
   input  logic [DWELL_W-1:0] DWELL,
   input  logic               SEL_DATA,
   output logic [1:0]         SEL_OUT,
   output logic [3:0]         SAMPLE,
   output logic               BUSY,
   output logic               DONE
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t             state_q,  state_d;
   logic [3:0]         mask_q,   mask_d;
   logic [DWELL_W-1:0] dwell_q,  dwell_d;
   logic [DWELL_W-1:0] cnt_q,    cnt_d;
   logic [1:0]         sel_q,    sel_d;
   logic [3:0]         sample_q, sample_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   // Channel search helpers
   logic [1:0] first_ch;   // lowest enabled channel of the incoming MASK
   logic [1:0] next_ch;    // next enabled channel above sel_q in the latched mask
   logic       has_next;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      first_ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (MASK[i]) first_ch = 2'(i);
      end

      next_ch  = 2'd0;
      has_next = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!has_next && mask_q[i] && (2'(i) > sel_q)) begin
            next_ch  = 2'(i);
            has_next = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      sample_d = sample_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (START) begin
               if (MASK != 4'b0000) begin
                  mask_d  = MASK;
                  dwell_d = (DWELL == '0) ? CNT_ONE : DWELL;
                  sel_d   = first_ch;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = SCAN;
               end else begin
                  // Empty mask: report completion without touching SEL_OUT/SAMPLE.
                  done_d  = 1'b1;
                  state_d = FINISH;
               end
            end
         end

         SCAN: begin
            busy_d = 1'b1;
            if (cnt_q == dwell_q - CNT_ONE) begin
               // Last cycle of this channel's dwell: capture the returned bit.
               sample_d[sel_q] = SEL_DATA;
               cnt_d           = '0;
               if (has_next) begin
                  sel_d = next_ch;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = FINISH;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of the others.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         dwell_q  <= CNT_ONE;
         cnt_q    <= '0;
         sel_q    <= '0;
         sample_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         dwell_q  <= dwell_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         sample_q <= sample_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign SEL_OUT = sel_q;
   assign SAMPLE  = sample_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

endmodule

// File: doc/sel_scan_ctrl.md
SEL_SCAN_CTRL -- requirements
Module: sel_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 4, width of the per-channel dwell count.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  input  1  scan request, sampled on the CLK edge.
REQ-005 SHALL have port MASK  input  4  channel enables; bit n enables channel n.
REQ-006 SHALL have port DWELL  input  DWELL_W  cycles per channel; 0 treated as 1.
REQ-007 SHALL have port SEL_DATA  input  1  data bit returned by the downstream 4-to-1 selector OUT.
REQ-008 SHALL have port SEL_OUT  output  2  select code driving the downstream selector SEL_IN.
REQ-009 SHALL have port SAMPLE  output  4  captured bit per channel.
REQ-010 SHALL have port BUSY  output  1  high while a scan is in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse at scan completion.

Function
REQ-012 SHALL implement states IDLE, SCAN, FINISH; all outputs registered.
REQ-013 In IDLE, START=1 with MASK!=0 at edge k SHALL latch MASK and D=max(DWELL,1), set SEL_OUT to lowest enabled channel, clear dwell counter, enter SCAN; BUSY=1 from edge k.
REQ-014 In IDLE, START=1 with MASK==0 SHALL enter FINISH directly; no channel sampled, SEL_OUT unchanged.
REQ-015 In SCAN, counter SHALL increment each edge; at the edge where counter==D-1, SEL_DATA SHALL be captured into SAMPLE[SEL_OUT].
REQ-016 At that capture edge, if a higher enabled channel exists in the latched mask, SEL_OUT SHALL advance to the next higher enabled channel and counter SHALL clear; otherwise the state SHALL go to FINISH.
REQ-017 Each enabled channel SHALL therefore hold SEL_OUT stable for exactly D cycles; disabled channels SHALL be skipped with zero cycles.
REQ-018 Channels SHALL be scanned in ascending order 0..3; no wrap-around within one scan.
REQ-019 FINISH SHALL last one cycle with DONE=1, BUSY=0, then return to IDLE; DONE SHALL be 0 in all other states.
REQ-020 START while in SCAN or FINISH SHALL be ignored; MASK/DWELL changes during a scan SHALL have no effect.
REQ-021 SAMPLE bits of disabled channels SHALL retain their previous value.
REQ-022 SEL_OUT SHALL hold its last value in IDLE.
REQ-023 Counter SHALL be DWELL_W bits; DWELL=2^DWELL_W-1 SHALL give exactly that many cycles without overflow.
REQ-024 Total scan length from START edge to DONE edge SHALL be D x (number of enabled channels) cycles; the DONE pulse follows in the next cycle.

Reset
REQ-025 RST=1 SHALL immediately, without a CLK edge, force state IDLE, SEL_OUT=0, SAMPLE=0, BUSY=0, DONE=0, counter=0.
REQ-026 RST asserted mid-scan SHALL abort the scan with no DONE pulse; SAMPLE SHALL read 0 after reset.
REQ-027 First START accepted SHALL be on the first CLK edge after RST deasserts.

Verification
REQ-028 MASK=4'b1111, DWELL=3, SEL_DATA driven as IN[SEL_OUT] with IN=4'b1010 -> SEL_OUT 0,1,2,3 each 3 cycles; DONE at cycle 13 after START; SAMPLE=4'b1010.
REQ-029 MASK=4'b1010, DWELL=2, IN=4'b1111, SAMPLE preloaded 0 -> SEL_OUT 1 then 3, 2 cycles each; SAMPLE=4'b1010; DONE 5 cycles after START.
REQ-030 MASK=0, START pulse -> DONE on next cycle, BUSY never high, SEL_OUT and SAMPLE unchanged.
REQ-031 DWELL=0, MASK=4'b0001, IN=4'b0001 -> single 1-cycle dwell on channel 0; SAMPLE[0]=1; DONE 2 cycles after START.
REQ-032 START held high through a scan with MASK changed mid-scan -> one scan using the original mask; a second scan starts on the first edge after FINISH.
REQ-033 RST pulsed between clock edges during SCAN -> outputs zero immediately, no DONE; a new START after release runs a full scan.
